// File: rtl/macguffin_decryption_if.sv
// AXI4-Stream bundle shared by the ciphertext input and the plaintext output.
interface macguffin_decryption_if #(
   parameter int unsigned DATA_W = 64
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/macguffin_decryption.sv
// Iterative MacGuffin decryptor: one unbalanced-Feistel round per clock,
// round keys applied last-to-first so it undoes the matching encryption core.
module macguffin_decryption #(
   parameter int unsigned ROUNDS = 32,
   parameter int unsigned KEY_W  = 48
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ROUNDS-1:0][KEY_W-1:0] round_keys,
   macguffin_decryption_if.slave        s_axis,
   macguffin_decryption_if.master       m_axis
);

   localparam int unsigned RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

   // Eight 6-in/2-out S-boxes; entry n of box j lives at bits [2n+1:2n].
   localparam logic [7:0][127:0] SBOX = {
      128'h2FFD_72DB_D01A_DFB7_B8E1_AFED_6A26_7E96,
      128'h9216_D5D9_8979_FB1B_D131_0BA6_98DF_B5AC,
      128'hC0AC_29B7_C97C_50DD_3F84_D5B5_B547_0917,
      128'h4528_21E6_38D0_1377_BE54_66CF_34E9_0C6C,
      128'hA409_3822_299F_31D0_082E_FA98_EC4E_6C89,
      128'h243F_6A88_85A3_08D3_1319_8A2E_0370_7344,
      128'h9E37_79B9_7F4A_7C15_F39C_C060_5CED_C834,
      128'h3C5A_96F0_E12D_7B48_A5C3_0F69_D28E_14B7
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [15:0] f_round(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] c,
                                           input logic [47:0] k);
      logic [15:0] w_a, w_b, w_c, w_o;
      logic [5:0]  w_idx;
      w_a = a ^ k[15:0];
      w_b = b ^ k[31:16];
      w_c = c ^ k[47:32];
      w_o = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         w_idx = {w_a[2*j +: 2], w_b[(2*j+4)%16 +: 2], w_c[(2*j+10)%16 +: 2]};
         w_o[2*j +: 2] = SBOX[j][{w_idx, 1'b0} +: 2];
      end
      return w_o;
   endfunction

   state_t           r_state, w_state_nxt;
   logic [63:0]      r_data,  w_data_nxt;
   logic [RND_W-1:0] r_rnd,   w_rnd_nxt;
   logic [63:0]      w_step;
   logic             w_s_ready;

   // (x0,x1,x2,x3) <- (x3 ^ f(x0,x1,x2,k), x0, x1, x2)
   assign w_step = {r_data[47:32], r_data[31:16], r_data[15:0],
                    r_data[63:48] ^ f_round(r_data[15:0], r_data[31:16],
                                            r_data[47:32], round_keys[r_rnd])};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data <= '0;
         r_rnd  <= '0;
      end else begin
         r_data <= w_data_nxt;
         r_rnd  <= w_rnd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_rnd_nxt   = r_rnd;
      w_s_ready   = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_s_ready = 1'b1;
            if (s_axis.tvalid) begin
               w_data_nxt  = s_axis.tdata;
               w_rnd_nxt   = RND_LAST;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_data_nxt = w_step;
            if (r_rnd == '0) w_state_nxt = DONE;
            else             w_rnd_nxt   = r_rnd - RND_W'(1);
         end
         DONE: begin
            // Output handshake doubles as the next input handshake: no bubble.
            w_s_ready = m_axis.tready;
            if (m_axis.tready) begin
               if (s_axis.tvalid) begin
                  w_data_nxt  = s_axis.tdata;
                  w_rnd_nxt   = RND_LAST;
                  w_state_nxt = RUN;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Gated by rst so tready is low for the whole reset, not just after it.
   assign s_axis.tready = rst & w_s_ready;
   assign m_axis.tvalid = (r_state == DONE);
   assign m_axis.tdata  = r_data;

endmodule

// File: tb/tb_macguffin_decryption.sv
// Directed bench for macguffin_decryption: ciphertexts come from an
// encryption-direction reference model, expected plaintexts are the originals.
module tb_macguffin_decryption;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0][47:0] keys;
   int unsigned      cyc = 0;
   int unsigned      n_vec = 0;
   int unsigned      n_fail = 0;

   macguffin_decryption_if #(.DATA_W(64)) s_if ();
   macguffin_decryption_if #(.DATA_W(64)) m_if ();

   macguffin_decryption #(.ROUNDS(32), .KEY_W(48)) dut (
      .clk        (clk),
      .rst        (rst),
      .round_keys (keys),
      .s_axis     (s_if),
      .m_axis     (m_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] sbox(input int j);
      case (j)
         0: return 128'h3C5A96F0E12D7B48A5C30F69D28E14B7;
         1: return 128'h9E3779B97F4A7C15F39CC0605CEDC834;
         2: return 128'h243F6A8885A308D313198A2E03707344;
         3: return 128'hA4093822299F31D0082EFA98EC4E6C89;
         4: return 128'h452821E638D01377BE5466CF34E90C6C;
         5: return 128'hC0AC29B7C97C50DD3F84D5B5B5470917;
         6: return 128'h9216D5D98979FB1BD1310BA698DFB5AC;
         default: return 128'h2FFD72DBD01ADFB7B8E1AFED6A267E96;
      endcase
   endfunction

   function automatic logic [15:0] fr(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [47:0] k);
      logic [15:0]  xa, xb, xc, o;
      logic [127:0] t;
      int           ix;
      xa = a ^ k[15:0];
      xb = b ^ k[31:16];
      xc = c ^ k[47:32];
      o  = 16'h0000;
      for (int j = 0; j < 8; j++) begin
         t  = sbox(j);
         ix = 32 * int'(xa[2*j+1]) + 16 * int'(xa[2*j])
            + 8 * int'(xb[(2*j+5)%16]) + 4 * int'(xb[(2*j+4)%16])
            + 2 * int'(xc[(2*j+11)%16]) + int'(xc[(2*j+10)%16]);
         o[2*j+1] = t[2*ix+1];
         o[2*j]   = t[2*ix];
      end
      return o;
   endfunction

   function automatic logic [63:0] enc(input logic [63:0] d, input logic [31:0][47:0] k);
      logic [15:0] x [4];
      logic [15:0] t;
      for (int w = 0; w < 4; w++) x[w] = d[16*w +: 16];
      for (int i = 0; i < 32; i++) begin
         x[0] = x[0] ^ fr(x[1], x[2], x[3], k[i]);
         t = x[0]; x[0] = x[1]; x[1] = x[2]; x[2] = x[3]; x[3] = t;
      end
      return {x[3], x[2], x[1], x[0]};
   endfunction

   // Undo each encryption round: un-rotate, then re-apply the XOR.
   function automatic logic [63:0] dec(input logic [63:0] d, input logic [31:0][47:0] k);
      logic [15:0] x [4];
      logic [15:0] t;
      for (int w = 0; w < 4; w++) x[w] = d[16*w +: 16];
      for (int i = 31; i >= 0; i--) begin
         t = x[3]; x[3] = x[2]; x[2] = x[1]; x[1] = x[0]; x[0] = t;
         x[0] = x[0] ^ fr(x[1], x[2], x[3], k[i]);
      end
      return {x[3], x[2], x[1], x[0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered just after a negedge; returns just after a negedge with the edge of
   // the input handshake in e0.
   task automatic push(input logic [63:0] d, output int unsigned e0);
      int unsigned n = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      #1;
      while (s_if.tready !== 1'b1 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 200) chk("in_timeout", {63'd0, s_if.tready}, 64'd1);
      @(posedge clk); #1;
      e0 = cyc;
      s_if.tvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_out(output int unsigned seen);
      int unsigned n = 0;
      while (m_if.tvalid !== 1'b1 && n < 200) begin
         @(negedge clk); n++;
      end
      if (n >= 200) chk("out_timeout", {63'd0, m_if.tvalid}, 64'd1);
      seen = cyc;
   endtask

   task automatic pull(input string tag, input logic [63:0] exp, input int unsigned e0);
      int unsigned seen;
      wait_out(seen);
      chk(tag, m_if.tdata, exp);
      chk({tag, "_lat"}, 64'(seen - e0), 64'd32);
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   logic [63:0]  pt, ct, exp_z;
   int unsigned  e0, seen;
   logic [63:0]  b_pt [4];
   logic [63:0]  b_ct [4];
   int unsigned  hs_in [4];
   int unsigned  hs_out [4];

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      m_if.tready = 1'b1;
      for (int i = 0; i < 32; i++)
         keys[i] = {16'(i * 16'h1F3B + 16'h0A5C), 16'((i * 16'h7E15) ^ 16'hC3D2),
                    16'((i + 1) * 16'h2B61)};

      // Reset state
      #3 rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", {63'd0, m_if.tvalid}, 64'd0);
      chk("rst_tdata",  m_if.tdata, 64'd0);
      chk("rst_sready", {63'd0, s_if.tready}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_sready", {63'd0, s_if.tready}, 64'd1);

      // Loopback of the reference plaintext
      ct = enc(64'h0123456789ABCDEF, keys);
      push(ct, e0);
      pull("loopback", 64'h0123456789ABCDEF, e0);
      chk("idle_sready", {63'd0, s_if.tready}, 64'd1);

      // Backpressure for 50 cycles
      m_if.tready = 1'b0;
      pt = 64'hFEDCBA9876543210;
      push(enc(pt, keys), e0);
      wait_out(seen);
      chk("bp_lat", 64'(seen - e0), 64'd32);
      for (int k = 0; k < 50; k++) begin
         chk("bp_data", m_if.tdata, pt);
         chk("bp_flags", {62'd0, m_if.tvalid, s_if.tready}, 64'd2);
         @(negedge clk);
      end
      m_if.tready = 1'b1;
      #1;
      chk("bp_release_sready", {63'd0, s_if.tready}, 64'd1);
      @(negedge clk);
      chk("bp_one_hs", {62'd0, m_if.tvalid, s_if.tready}, 64'd1);

      // Back-to-back: 4 blocks, s_tvalid held high
      for (int i = 0; i < 4; i++) begin
         b_pt[i] = {32'(i * 32'h1111_1111), 32'(~(i * 32'h0F0F_0F0F))};
         b_ct[i] = enc(b_pt[i], keys);
      end
      fork
         begin : producer
            for (int i = 0; i < 4; i++) begin
               int unsigned n;
               n = 0;
               s_if.tvalid = 1'b1;
               s_if.tdata  = b_ct[i];
               #1;
               while (s_if.tready !== 1'b1 && n < 200) begin
                  @(negedge clk); #1; n++;
               end
               if (n >= 200) chk("b2b_in_timeout", {63'd0, s_if.tready}, 64'd1);
               @(posedge clk); #1;
               hs_in[i] = cyc;
            end
            s_if.tvalid = 1'b0;
         end
         begin : consumer
            for (int i = 0; i < 4; i++) begin
               int unsigned sn;
               wait_out(sn);
               chk("b2b_data", m_if.tdata, b_pt[i]);
               chk("b2b_lat", 64'(sn - hs_in[i]), 64'd32);
               @(posedge clk); #1;
               hs_out[i] = cyc;
               @(negedge clk);
            end
         end
      join
      for (int i = 0; i < 3; i++)
         chk("b2b_no_bubble", 64'(hs_in[i+1]), 64'(hs_out[i]));
      @(negedge clk);
      chk("b2b_drained", {63'd0, m_if.tvalid}, 64'd0);

      // Reset mid-block
      push(enc(64'hDEADBEEFCAFEF00D, keys), e0);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("midrst_tvalid", {63'd0, m_if.tvalid}, 64'd0);
         chk("midrst_tdata",  m_if.tdata, 64'd0);
         chk("midrst_sready", {63'd0, s_if.tready}, 64'd0);
         @(negedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_release_sready", {63'd0, s_if.tready}, 64'd1);
      chk("midrst_release_tvalid", {63'd0, m_if.tvalid}, 64'd0);
      pt = 64'h0F1E2D3C4B5A6978;
      push(enc(pt, keys), e0);
      pull("after_rst", pt, e0);

      // All-zero keys and ciphertext, twice
      keys  = '0;
      exp_z = dec(64'd0, keys);
      push(64'd0, e0);
      pull("zero_first", exp_z, e0);
      push(64'd0, e0);
      pull("zero_again", exp_z, e0);

      // Golden pairs, in order, m_tready held high
      for (int i = 0; i < 32; i++)
         keys[i] = {16'(i * 16'h3A7D + 16'h5E01), 16'((i * 16'h0B3B) ^ 16'h9C4F),
                    16'(i * 16'hD21F + 16'h1234)};
      for (int g = 0; g < 100; g++) begin
         pt = {$urandom, $urandom};
         push(enc(pt, keys), e0);
         pull("golden", pt, e0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
